// File: rtl/fetch_instruction_memory.sv
// fetch_instruction_memory: loadable instruction memory with fetch/stall handshake and fault flags.
module fetch_instruction_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = 32,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  fetch_en,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  output logic                  fault_misaligned,
  output logic                  fault_range,
  output logic                  running,
  output logic                  load_overflow
);
  typedef enum logic {LOAD, RUN} state_t;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  state_t                  state_q;
  logic [IDX_W-1:0]        wptr_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   data_q, rdata_d;
  logic                    valid_q, mis_q, rng_q, ovf_q;
  logic                    mis_d, rng_d, we_d;
  assign we_d    = state_q == LOAD && load_valid;
  assign mis_d   = |address[1:0];
  // any index bit at or above DEPTH puts the word outside the array
  assign rng_d   = |address[ADDR_WIDTH-1:IDX_W+2];
  assign rdata_d = (mis_d || rng_d) ? '0 : mem[address[IDX_W+1:2]];
  assign load_ready       = state_q == LOAD;
  assign running          = state_q == RUN;
  assign data             = data_q;
  assign data_valid       = valid_q;
  assign fault_misaligned = mis_q;
  assign fault_range      = rng_q;
  assign load_overflow    = ovf_q;
  always_ff @(posedge clock)
    if (we_d) mem[wptr_q] <= load_data;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= LOAD;
      wptr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      rng_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == LOAD) begin
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      rng_q   <= 1'b0;
      if (load_valid) begin
        wptr_q <= wptr_q + IDX_W'(1);
        if (load_last || wptr_q == LAST_IDX) state_q <= RUN;
        if (!load_last && wptr_q == LAST_IDX) ovf_q <= 1'b1;
      end
    end else if (load_start) begin
      state_q <= LOAD;
      wptr_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      rng_q   <= 1'b0;
    end else if (!stall) begin
      valid_q <= fetch_en;
      mis_q   <= fetch_en && mis_d;
      rng_q   <= fetch_en && rng_d;
      if (fetch_en) data_q <= rdata_d;
    end
endmodule

// File: tb/tb_fetch_instruction_memory.sv
// tb_fetch_instruction_memory: directed stimulus checked every cycle against a behavioural model.
module tb_fetch_instruction_memory;
  localparam int DEPTH = 128;
  logic        clk = 0, rst_n = 0;
  logic        fetch_en = 0, stall = 0, load_start = 0, load_valid = 0, load_last = 0;
  logic [31:0] address = 0, load_data = 0;
  logic        load_ready, data_valid, fault_misaligned, fault_range, running, load_overflow;
  logic [31:0] data;
  int          checks = 0, failures = 0;

  fetch_instruction_memory #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(32)) dut (
    .clock(clk), .reset_n(rst_n), .fetch_en(fetch_en), .stall(stall), .address(address),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .data(data), .data_valid(data_valid),
    .fault_misaligned(fault_misaligned), .fault_range(fault_range),
    .running(running), .load_overflow(load_overflow));

  always #5 clk = ~clk;

  // model: plain word array, word counter and flags
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_data, m_idx;
  int          m_wptr;
  bit          m_run, m_ovf, m_valid, m_mis, m_rng;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_wptr = 0; m_ovf = 0; m_valid = 0; m_mis = 0; m_rng = 0; m_data = 0;
    end else if (!m_run) begin
      m_valid = 0; m_mis = 0; m_rng = 0;
      if (load_valid) begin
        m_mem[m_wptr] = load_data;
        if (load_last) m_run = 1;
        else if (m_wptr == DEPTH - 1) begin m_ovf = 1; m_run = 1; end
        m_wptr = (m_wptr + 1) % DEPTH;
      end
    end else if (load_start) begin
      m_run = 0; m_wptr = 0; m_ovf = 0; m_valid = 0; m_mis = 0; m_rng = 0;
    end else if (!stall) begin
      if (fetch_en) begin
        m_idx   = address / 4;
        m_mis   = (address % 4) != 0;
        m_rng   = m_idx >= DEPTH;
        m_data  = (m_mis || m_rng) ? 32'h0 : m_mem[m_idx[6:0]];
        m_valid = 1;
      end else begin
        m_valid = 0; m_mis = 0; m_rng = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("data", data, m_data);
    chk("data_valid", {31'b0, data_valid}, {31'b0, m_valid});
    chk("fault_misaligned", {31'b0, fault_misaligned}, {31'b0, m_mis});
    chk("fault_range", {31'b0, fault_range}, {31'b0, m_rng});
    chk("running", {31'b0, running}, {31'b0, m_run});
    chk("load_ready", {31'b0, load_ready}, {31'b0, !m_run});
    chk("load_overflow", {31'b0, load_overflow}, {31'b0, m_ovf});
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [31:0] w, input logic last);
    load_valid = 1; load_data = w; load_last = last;
    step();
    load_valid = 0; load_last = 0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_en = 1; address = a;
    step();
  endtask

  initial begin
    step(); step();
    chk("rst_data", data, 32'h0);
    chk("rst_valid", {31'b0, data_valid}, 32'h0);
    chk("rst_ready", {31'b0, load_ready}, 32'h1);
    chk("rst_running", {31'b0, running}, 32'h0);
    rst_n = 1;
    step();
    load(32'h20010010, 0); load(32'h00000000, 0); load(32'hAC010004, 0); load(32'h8C020004, 1);
    chk("run_after_last", {31'b0, running}, 32'h1);
    fetch(0);  chk("fetch0", data, 32'h20010010);
    fetch(4);  chk("fetch4", data, 32'h00000000);
    fetch(8);  chk("fetch8", data, 32'hAC010004);
    fetch(12); chk("fetch12", data, 32'h8C020004);
    chk("fetch12_valid", {31'b0, data_valid}, 32'h1);
    fetch(6);
    chk("mis_flag", {31'b0, fault_misaligned}, 32'h1);
    chk("mis_data", data, 32'h0);
    fetch(32'h200);
    chk("rng_flag", {31'b0, fault_range}, 32'h1);
    chk("rng_mis", {31'b0, fault_misaligned}, 32'h0);
    fetch(32'h202);
    chk("both_faults", {30'b0, fault_misaligned, fault_range}, 32'h3);
    fetch(8);
    stall = 1; address = 0;
    step(); step(); step();
    chk("stall_data", data, 32'hAC010004);
    chk("stall_valid", {31'b0, data_valid}, 32'h1);
    stall = 0;
    step();
    chk("post_stall", data, 32'h20010010);
    fetch_en = 0;
    step();
    chk("idle_valid", {31'b0, data_valid}, 32'h0);
    chk("idle_hold", data, 32'h20010010);
    fetch_en = 1; address = 4; load_start = 1;
    step();
    load_start = 0; fetch_en = 0;
    chk("ls_valid", {31'b0, data_valid}, 32'h0);
    chk("ls_ready", {31'b0, load_ready}, 32'h1);
    load(32'hDEADBEEF, 1);
    fetch(0); chk("reload0", data, 32'hDEADBEEF);
    rst_n = 0; #1;
    chk("async_valid", {31'b0, data_valid}, 32'h0);
    chk("async_data", data, 32'h0);
    fetch_en = 0;
    step(); rst_n = 1;
    load(32'h11111111, 0); load(32'h22222222, 0);
    rst_n = 0; step(); rst_n = 1;
    load(32'h33333333, 0); load(32'h44444444, 1);
    fetch(0); chk("new0", data, 32'h33333333);
    fetch(4); chk("new1", data, 32'h44444444);
    fetch(8); chk("stale2", data, 32'hAC010004);
    fetch_en = 0; load_start = 1;
    step();
    load_start = 0;
    for (int i = 0; i < DEPTH; i++) load(32'(i * 3 + 1), 0);
    chk("ovf_flag", {31'b0, load_overflow}, 32'h1);
    chk("ovf_running", {31'b0, running}, 32'h1);
    load(32'hFFFFFFFF, 0);
    fetch(0);   chk("ovf_mem0", data, 32'h1);
    fetch(508); chk("ovf_mem127", data, 32'd382);
    fetch_en = 0;
    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_instruction_memory.md
# fetch_instruction_memory

Parametrised instruction memory for the Mini-MIPS fetch stage, successor to the fixed 128-word ROM. It adds a sequential load port, so a program is streamed in after reset instead of being hard-coded. It also adds a fetch request/valid handshake with pipeline stall hold, and fault flags for misaligned or out-of-range PCs. It sits between the PC register and the IF/ID pipeline register.

## Interface
- DATA_WIDTH, 32, instruction word width
- DEPTH, 128, number of words; power of two, >= 2
- ADDR_WIDTH, 32, byte-address width of the PC
- IDX_W, $clog2(DEPTH), word-index width (derived, not overridden)

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- fetch_en  in  1  fetch request for `address` this cycle
- stall  in  1  hold all fetch outputs (IF/ID stall)
- address  in  ADDR_WIDTH  byte address (PC)
- load_start  in  1  abandon RUN and restart loading at word 0
- load_valid  in  1  load_data is valid this cycle
- load_data  in  DATA_WIDTH  program word
- load_last  in  1  qualifies load_valid: final word of program
- load_ready  out  1  high in LOAD state
- data  out  DATA_WIDTH  fetched instruction (registered)
- data_valid  out  1  data holds a fetch result
- fault_misaligned  out  1  last fetch had address[1:0] != 0
- fault_range  out  1  last fetch had word index >= DEPTH
- running  out  1  high in RUN state
- load_overflow  out  1  sticky: memory filled without load_last

## Operation
- State machine states: LOAD and RUN. Reset enters LOAD. The write pointer `wptr` (IDX_W bits) resets to 0.
- **LOAD state**
  - load_ready = 1.
  - A cycle with load_valid=1 writes load_data to mem[wptr] and increments wptr.
  - load_valid with load_last=1 writes the word, then goes to RUN.
  - load_valid at wptr == DEPTH-1 with load_last=0 writes the word, sets load_overflow, wraps wptr to 0 and goes to RUN. Later words are not accepted.
  - fetch_en is ignored; data_valid is forced to 0.
- **RUN state**
  - running = 1, load_ready = 0, load_valid ignored.
  - load_start=1 goes to LOAD, clears wptr and load_overflow, and takes priority over a simultaneous fetch (data_valid = 0 next cycle).
- **Fetch in RUN, stall=0, fetch_en=1**
  - Word index is address[ADDR_WIDTH-1:2].
  - Misaligned: fault_misaligned=1, data=0 (nop).
  - Else if index >= DEPTH: fault_range=1, data=0. Both faults may be set together.
  - Else: data=mem[address[IDX_W+1:2]], both faults 0.
  - data_valid=1 in all three cases.
- **Fetch in RUN, stall=0, fetch_en=0**: data_valid=0 and faults cleared; data holds its last value.
- **stall=1**: data, data_valid and both faults hold, regardless of fetch_en. load_start still acts.
- The memory array is not reset; contents survive reset and load_start until overwritten.
- No read-during-write hazard exists, because writes occur only in LOAD and reads only in RUN.

## Timing
- Fetch latency is 1 cycle: address is sampled on edge N and data/valid/fault are visible after edge N.
- A load write commits on the edge where load_valid=1. The transition to RUN happens on the same edge as the load_last write, so a fetch is accepted on the next cycle.
- load_start is sampled on edge N: running=0 and load_ready=1 after edge N.
- **Reset values**
  - data = 0, data_valid = 0, both faults = 0, load_overflow = 0, running = 0.
  - load_ready = 1, because state resets to LOAD; it is decoded from state.
  - wptr = 0.
- Reset mid-load: the state returns to LOAD and wptr to 0. Words already written remain in memory.
- Reset mid-RUN: all fetch outputs clear immediately (asynchronously).

## Test plan
- Load 0x20010010, 0x00000000, 0xAC010004, 0x8C020004 (last on the 4th). Then fetch 0, 4, 8, 12 on consecutive cycles → data equals each word one cycle later, with data_valid=1.
- Fetch address 0x6 → fault_misaligned=1, data=0, data_valid=1. Fetch 0x200 with DEPTH=128 → fault_range=1, data=0.
- Fetch 0x8, then hold stall=1 for 3 cycles while address changes to 0x0 → data stays 0xAC010004 and valid stays 1. Release stall → next result is mem[0].
- DEPTH=4: load 4 words without load_last → load_overflow=1, running=1. A 5th load_valid is ignored and mem[0] is unchanged.
- Assert reset_n=0 after 2 of 4 load words, then load 2 new words with last → mem[0..1] hold the new words and mem[2..3] hold stale data. Fetch 8 returns stale mem[2].
- In RUN, assert load_start with fetch_en=1 → data_valid=0 and load_ready=1 next cycle. Reload 1 word with last → fetch 0 returns the new word.
